// File: rtl/issue_queue.sv
// Age-ordered reservation station for one execution lane: holds renamed uops until
// both operands are woken, then issues the oldest ready entry (by sqN) each cycle.
module issue_queue #(
  parameter int SIZE    = 8,
  parameter int NUM_WBS = 4,
  parameter int UOP_W   = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       IN_uopValid,
  input  logic [UOP_W-1:0]           IN_uop,
  input  logic                       IN_availA,
  input  logic                       IN_availB,
  input  logic [NUM_WBS-1:0]         IN_wbHasResult,
  input  logic [NUM_WBS*7-1:0]       IN_wbTag,
  input  logic                       IN_invalidate,
  input  logic [6:0]                 IN_invalidateSqN,
  input  logic                       IN_stall,
  output logic                       OUT_full,
  output logic [$clog2(SIZE+1)-1:0]  OUT_count,
  output logic                       OUT_uopValid,
  output logic [UOP_W-1:0]           OUT_uop
);
  localparam int IW = $clog2(SIZE);
  localparam int CW = $clog2(SIZE+1);

  logic [SIZE-1:0]             valid;
  logic [SIZE-1:0]             avail_a, avail_b;
  logic [SIZE-1:0][UOP_W-1:0]  q_uop;
  logic [SIZE-1:0][6:0]        sqn;
  logic [SIZE-1:0]             flush, cand, wake_a, wake_b;

  // Immediate tags (bit6) never match a writeback.
  function automatic logic wb_match(input logic [6:0] tag, input logic [NUM_WBS-1:0] has,
                                    input logic [NUM_WBS*7-1:0] tags);
    logic m;
    m = 1'b0;
    for (int j = 0; j < NUM_WBS; j++)
      if (has[j] && tags[j*7 +: 7] == tag) m = 1'b1;
    return m && !tag[6];
  endfunction

  function automatic logic older(input logic [6:0] x, input logic [6:0] y);
    logic [6:0] d;
    d = x - y;
    return d[6];
  endfunction

  function automatic logic younger_than_inv(input logic [6:0] x, input logic [6:0] inv);
    logic [6:0] d;
    d = x - inv;
    return !d[6] && (d != 7'd0);
  endfunction

  for (genvar i = 0; i < SIZE; i++) begin : g_ent
    assign sqn[i]    = q_uop[i][50:44];
    assign flush[i]  = valid[i] && IN_invalidate && younger_than_inv(sqn[i], IN_invalidateSqN);
    assign cand[i]   = valid[i] && avail_a[i] && avail_b[i] && !flush[i];
    assign wake_a[i] = wb_match(q_uop[i][66:60], IN_wbHasResult, IN_wbTag);
    assign wake_b[i] = wb_match(q_uop[i][58:52], IN_wbHasResult, IN_wbTag);
  end

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] free_idx;
  logic [CW-1:0] cnt;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    cnt       = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (cand[i] && (!sel_found || older(sqn[i], sqn[sel_idx]))) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
      cnt = cnt + CW'(valid[i]);
    end
    for (int i = SIZE-1; i >= 0; i--)
      if (!valid[i]) free_idx = IW'(i);
  end

  assign OUT_full  = &valid;
  assign OUT_count = cnt;

  // Incoming uop: readiness folds in same-cycle wakeups so none are lost.
  logic in_flush, enq, issue, in_a, in_b, out_flush;
  assign in_flush  = IN_invalidate && younger_than_inv(IN_uop[50:44], IN_invalidateSqN);
  assign enq       = IN_uopValid && !OUT_full && !in_flush;
  assign issue     = !IN_stall && sel_found;
  assign in_a      = IN_availA | IN_uop[66] | wb_match(IN_uop[66:60], IN_wbHasResult, IN_wbTag);
  assign in_b      = IN_availB | IN_uop[58] | IN_uop[51] |
                     wb_match(IN_uop[58:52], IN_wbHasResult, IN_wbTag);
  assign out_flush = IN_invalidate && younger_than_inv(OUT_uop[50:44], IN_invalidateSqN);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid        <= '0;
      OUT_uopValid <= 1'b0;
      OUT_uop      <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++)
        if (flush[i] || (issue && sel_idx == IW'(i))) valid[i] <= 1'b0;
      if (enq) valid[free_idx] <= 1'b1;
      if (!IN_stall) begin
        OUT_uopValid <= sel_found;
        if (sel_found) OUT_uop <= q_uop[sel_idx];
      end else if (out_flush) begin
        OUT_uopValid <= 1'b0;
      end
    end
  end

  // Payload and readiness need no reset: they are only meaningful under valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (wake_a[i]) avail_a[i] <= 1'b1;
      if (wake_b[i]) avail_b[i] <= 1'b1;
    end
    if (enq) begin
      q_uop[free_idx]   <= IN_uop;
      avail_a[free_idx] <= in_a;
      avail_b[free_idx] <= in_b;
    end
  end
endmodule
